// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the in-order RV32I core: PC and stage-register enables,
// bubble insertion, per-stage valid tracking, fetch redirect handling, saturating counters.
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES = 5,
   parameter int EX_STAGE   = 2,
   parameter int MEM_STAGE  = 3,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  imem_resp,
   input  logic                  dmem_op,
   input  logic                  dmem_resp,
   input  logic                  load_use,
   input  logic                  redirect,
   output logic                  imem_read,
   output logic                  load_pc,
   output logic                  fetch_ok,
   output logic [NUM_STAGES-2:0] stage_load,
   output logic [NUM_STAGES-2:0] stage_bubble,
   output logic [NUM_STAGES-1:0] stage_valid,
   output logic [CNT_W-1:0]      cnt_cycle,
   output logic [CNT_W-1:0]      cnt_retire,
   output logic [CNT_W-1:0]      cnt_stall,
   output logic [CNT_W-1:0]      cnt_flush
);

   typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DISCARD} fetch_state_e;

   fetch_state_e            state_q, state_d;
   logic [NUM_STAGES-1:1]   valid_q, valid_d;
   logic [CNT_W-1:0]        cycle_q, cycle_d;
   logic [CNT_W-1:0]        retire_q, retire_d;
   logic [CNT_W-1:0]        stall_q, stall_d;
   logic [CNT_W-1:0]        flush_q, flush_d;
   logic [NUM_STAGES-1:0]   cur_valid;
   logic                    dmem_stall;
   logic                    redir_acc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + 1'b1 : v;
   endfunction

   // The PC stage always holds a live instruction once out of reset.
   assign cur_valid = {valid_q, 1'b1};

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      valid_d      = valid_q;
      cycle_d      = cycle_q;
      retire_d     = retire_q;
      stall_d      = stall_q;
      flush_d      = flush_q;
      imem_read    = 1'b0;
      load_pc      = 1'b0;
      fetch_ok     = 1'b0;
      stage_load   = '0;
      stage_bubble = '0;
      dmem_stall   = 1'b0;
      redir_acc    = 1'b0;

      if (rst) begin
         state_d  = F_IDLE;
         valid_d  = '0;
         cycle_d  = '0;
         retire_d = '0;
         stall_d  = '0;
         flush_d  = '0;
      end else begin
         dmem_stall = dmem_op & valid_q[MEM_STAGE] & ~dmem_resp;
         redir_acc  = redirect & ~dmem_stall;
         fetch_ok   = (state_q == F_WAIT) & imem_resp & ~redir_acc;
         imem_read  = 1'b1;
         load_pc    = 1'b1;
         stage_load = '1;

         unique case (state_q)
            F_IDLE:    state_d = F_WAIT;
            F_WAIT:    if (~imem_resp & redir_acc) state_d = F_DISCARD;
            F_DISCARD: if (imem_resp & ~redir_acc) state_d = F_WAIT;
            default:   state_d = F_IDLE;
         endcase

         if (dmem_stall) begin
            load_pc = 1'b0;
            for (int i = 0; i < MEM_STAGE; i++) stage_load[i] = 1'b0;
            stage_bubble[MEM_STAGE] = 1'b1;
         end else if (redir_acc) begin
            for (int i = 0; i < EX_STAGE; i++) stage_bubble[i] = 1'b1;
         end else if (load_use) begin
            load_pc = 1'b0;
            for (int i = 0; i < EX_STAGE - 1; i++) stage_load[i] = 1'b0;
            stage_bubble[EX_STAGE-1] = 1'b1;
         end else if (~fetch_ok) begin
            load_pc         = 1'b0;
            stage_bubble[0] = 1'b1;
         end

         for (int i = 0; i < NUM_STAGES - 1; i++) begin
            if (stage_load[i]) valid_d[i+1] = cur_valid[i] & ~stage_bubble[i];
         end

         cycle_d  = sat_inc(cycle_q, 1'b1);
         retire_d = sat_inc(retire_q, cur_valid[NUM_STAGES-1] & stage_load[NUM_STAGES-2]);
         stall_d  = sat_inc(stall_q, ~load_pc);
         flush_d  = sat_inc(flush_q, redir_acc);
      end
   end

   always_ff @(posedge clk) begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
   end

   // Registered views are forced low while reset is held so every output reads 0.
   assign stage_valid = rst ? '0 : cur_valid;
   assign cnt_cycle   = rst ? '0 : cycle_q;
   assign cnt_retire  = rst ? '0 : retire_q;
   assign cnt_stall   = rst ? '0 : stall_q;
   assign cnt_flush   = rst ? '0 : flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, counter sequences and
// randomized traffic against a behavioural model of the control rules.
module tb_pipe_hazard_ctrl;
   localparam int N   = 5;
   localparam int EX  = 2;
   localparam int MEM = 3;
   localparam longint MAX32 = 64'hFFFF_FFFF;
   localparam longint MAX4  = 15;

   logic clk = 1'b0;
   logic rst = 1'b1, imem_resp = 1'b0, dmem_op = 1'b0, dmem_resp = 1'b0;
   logic load_use = 1'b0, redirect = 1'b0;
   logic imem_read, load_pc, fetch_ok;
   logic [N-2:0] stage_load, stage_bubble;
   logic [N-1:0] stage_valid;
   logic [31:0] cnt_cycle, cnt_retire, cnt_stall, cnt_flush;
   logic s_imem_read, s_load_pc, s_fetch_ok;
   logic [N-2:0] s_stage_load, s_stage_bubble;
   logic [N-1:0] s_stage_valid;
   logic [3:0] s_cnt_cycle, s_cnt_retire, s_cnt_stall, s_cnt_flush;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.NUM_STAGES(N), .EX_STAGE(EX), .MEM_STAGE(MEM), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_op(dmem_op), .dmem_resp(dmem_resp),
      .load_use(load_use), .redirect(redirect), .imem_read(imem_read), .load_pc(load_pc),
      .fetch_ok(fetch_ok), .stage_load(stage_load), .stage_bubble(stage_bubble),
      .stage_valid(stage_valid), .cnt_cycle(cnt_cycle), .cnt_retire(cnt_retire),
      .cnt_stall(cnt_stall), .cnt_flush(cnt_flush));

   pipe_hazard_ctrl #(.NUM_STAGES(N), .EX_STAGE(EX), .MEM_STAGE(MEM), .CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_op(dmem_op), .dmem_resp(dmem_resp),
      .load_use(load_use), .redirect(redirect), .imem_read(s_imem_read), .load_pc(s_load_pc),
      .fetch_ok(s_fetch_ok), .stage_load(s_stage_load), .stage_bubble(s_stage_bubble),
      .stage_valid(s_stage_valid), .cnt_cycle(s_cnt_cycle), .cnt_retire(s_cnt_retire),
      .cnt_stall(s_cnt_stall), .cnt_flush(s_cnt_flush));

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural model: a stale-response flag instead of a state machine, and
   // stall effects described as "registers below a limit hold" plus a bubble range.
   bit     m_fresh = 1'b1;
   bit     m_stale = 1'b0;
   bit     m_val [N];
   longint m_cyc = 0, m_ret = 0, m_stl = 0, m_fls = 0;
   bit     e_pc, e_fok, e_acc;
   bit [N-2:0] e_load, e_bub;
   bit [N-1:0] e_val;

   function automatic longint sat(input longint v, input longint mx);
      return (v < mx) ? v + 1 : v;
   endfunction

   function automatic longint cap(input longint v, input longint mx);
      return (v < mx) ? v : mx;
   endfunction

   task automatic model_eval();
      bit dstall;
      int hold_lim, b_lo, b_hi;
      e_pc = 0; e_fok = 0; e_acc = 0; e_load = '0; e_bub = '0; e_val = '0;
      if (rst) return;
      dstall = dmem_op && m_val[MEM] && !dmem_resp;
      e_acc  = redirect && !dstall;
      e_fok  = !m_fresh && !m_stale && imem_resp && !e_acc;
      hold_lim = 0; b_lo = 0; b_hi = -1; e_pc = 1;
      if (dstall) begin
         hold_lim = MEM; b_lo = MEM; b_hi = MEM; e_pc = 0;
      end else if (e_acc) begin
         b_hi = EX - 1;
      end else if (load_use) begin
         hold_lim = EX - 1; b_lo = EX - 1; b_hi = EX - 1; e_pc = 0;
      end else if (!e_fok) begin
         b_hi = 0; e_pc = 0;
      end
      for (int i = 0; i < N - 1; i++) begin
         e_load[i] = (i >= hold_lim);
         e_bub[i]  = (i >= b_lo) && (i <= b_hi);
      end
      e_val[0] = 1'b1;
      for (int i = 1; i < N; i++) e_val[i] = m_val[i];
   endtask

   task automatic model_update();
      if (rst) begin
         m_fresh = 1; m_stale = 0;
         for (int i = 0; i < N; i++) m_val[i] = 0;
         m_cyc = 0; m_ret = 0; m_stl = 0; m_fls = 0;
      end else begin
         if (e_val[N-1] && e_load[N-2]) m_ret = sat(m_ret, MAX32);
         m_cyc = sat(m_cyc, MAX32);
         if (!e_pc) m_stl = sat(m_stl, MAX32);
         if (e_acc) m_fls = sat(m_fls, MAX32);
         for (int i = 0; i < N - 1; i++)
            if (e_load[i]) m_val[i+1] = e_bub[i] ? 1'b0 : e_val[i];
         if (m_fresh) m_stale = 0;
         else if (e_acc) m_stale = m_stale || !imem_resp;
         else m_stale = m_stale && !imem_resp;
         m_fresh = 0;
      end
   endtask

   task automatic drive(input bit r, input bit resp, input bit dop, input bit dresp,
                        input bit lu, input bit rd);
      @(negedge clk);
      rst = r; imem_resp = resp; dmem_op = dop; dmem_resp = dresp;
      load_use = lu; redirect = rd;
      #1;
      model_eval();
      check("imem_read", imem_read, !r);
      check("load_pc", load_pc, e_pc);
      check("fetch_ok", fetch_ok, e_fok);
      check("stage_load", stage_load, e_load);
      check("stage_bubble", stage_bubble, e_bub);
      check("stage_valid", stage_valid, e_val);
      check("cnt_cycle", cnt_cycle, r ? 0 : m_cyc);
      check("cnt_retire", cnt_retire, r ? 0 : m_ret);
      check("cnt_stall", cnt_stall, r ? 0 : m_stl);
      check("cnt_flush", cnt_flush, r ? 0 : m_fls);
      check("small_cnt_cycle", s_cnt_cycle, r ? 0 : cap(m_cyc, MAX4));
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
   endtask

   typedef struct {
      bit r, resp, dop, dresp, lu, rd;
      bit e_pc, e_fok;
      bit [3:0] e_load, e_bub;
      bit [4:0] e_val;
   } vec_t;

   vec_t tbl [28];

   initial begin
      // r resp dop dresp lu rd | pc fok load bubble valid
      tbl[0]  = '{1,0,0,0,0,0, 0,0, 4'b0000, 4'b0000, 5'b00000};
      tbl[1]  = '{0,1,0,0,0,0, 0,0, 4'b1111, 4'b0001, 5'b00001};
      tbl[2]  = '{0,1,0,0,0,0, 1,1, 4'b1111, 4'b0000, 5'b00001};
      tbl[3]  = '{0,1,0,0,0,0, 1,1, 4'b1111, 4'b0000, 5'b00011};
      tbl[4]  = '{0,1,0,0,0,0, 1,1, 4'b1111, 4'b0000, 5'b00111};
      tbl[5]  = '{0,1,0,0,0,0, 1,1, 4'b1111, 4'b0000, 5'b01111};
      tbl[6]  = '{0,1,0,0,0,0, 1,1, 4'b1111, 4'b0000, 5'b11111};
      tbl[7]  = '{0,1,1,0,0,0, 0,1, 4'b1000, 4'b1000, 5'b11111};
      tbl[8]  = '{0,1,1,0,0,0, 0,1, 4'b1000, 4'b1000, 5'b01111};
      tbl[9]  = '{0,1,1,0,0,0, 0,1, 4'b1000, 4'b1000, 5'b01111};
      tbl[10] = '{0,1,1,1,0,0, 1,1, 4'b1111, 4'b0000, 5'b01111};
      tbl[11] = '{0,1,0,0,0,0, 1,1, 4'b1111, 4'b0000, 5'b11111};
      tbl[12] = '{0,0,0,0,0,1, 1,0, 4'b1111, 4'b0011, 5'b11111};
      tbl[13] = '{0,1,0,0,0,0, 0,0, 4'b1111, 4'b0001, 5'b11001};
      tbl[14] = '{0,1,0,0,0,0, 1,1, 4'b1111, 4'b0000, 5'b10001};
      tbl[15] = '{0,1,0,0,0,0, 1,1, 4'b1111, 4'b0000, 5'b00011};
      tbl[16] = '{0,1,0,0,1,0, 0,1, 4'b1110, 4'b0010, 5'b00111};
      tbl[17] = '{0,1,0,0,0,0, 1,1, 4'b1111, 4'b0000, 5'b01011};
      tbl[18] = '{0,1,0,0,0,0, 1,1, 4'b1111, 4'b0000, 5'b10111};
      tbl[19] = '{0,1,1,0,1,1, 0,1, 4'b1000, 4'b1000, 5'b01111};
      tbl[20] = '{0,1,1,1,1,1, 1,0, 4'b1111, 4'b0011, 5'b01111};
      tbl[21] = '{0,1,0,0,0,0, 1,1, 4'b1111, 4'b0000, 5'b11001};
      tbl[22] = '{0,0,0,0,0,1, 1,0, 4'b1111, 4'b0011, 5'b10011};
      tbl[23] = '{0,0,0,0,0,0, 0,0, 4'b1111, 4'b0001, 5'b00001};
      tbl[24] = '{1,0,0,0,0,0, 0,0, 4'b0000, 4'b0000, 5'b00000};
      tbl[25] = '{1,0,0,0,0,0, 0,0, 4'b0000, 4'b0000, 5'b00000};
      tbl[26] = '{0,1,0,0,0,0, 0,0, 4'b1111, 4'b0001, 5'b00001};
      tbl[27] = '{0,1,0,0,0,0, 1,1, 4'b1111, 4'b0000, 5'b00001};

      drive(1, 0, 0, 0, 0, 0);
      tick();

      for (int k = 0; k < 28; k++) begin
         drive(tbl[k].r, tbl[k].resp, tbl[k].dop, tbl[k].dresp, tbl[k].lu, tbl[k].rd);
         check($sformatf("row%0d load_pc", k), load_pc, tbl[k].e_pc);
         check($sformatf("row%0d fetch_ok", k), fetch_ok, tbl[k].e_fok);
         check($sformatf("row%0d stage_load", k), stage_load, tbl[k].e_load);
         check($sformatf("row%0d stage_bubble", k), stage_bubble, tbl[k].e_bub);
         check($sformatf("row%0d stage_valid", k), stage_valid, tbl[k].e_val);
         tick();
      end

      // Clean run from reset: retirement, stall and cycle counts by hand.
      drive(1, 0, 0, 0, 0, 0);
      tick();
      for (int k = 0; k < 15; k++) begin
         drive(0, 1, 0, 0, 0, 0);
         tick();
      end
      drive(0, 1, 0, 0, 0, 0);
      check("seq cnt_retire", cnt_retire, 10);
      check("seq cnt_stall", cnt_stall, 1);
      check("seq cnt_flush", cnt_flush, 0);
      check("seq cnt_cycle", cnt_cycle, 15);
      check("seq small cnt_cycle", s_cnt_cycle, 15);
      tick();
      for (int k = 0; k < 9; k++) begin
         drive(0, 1, 0, 0, 0, 0);
         tick();
      end
      drive(0, 1, 0, 0, 0, 0);
      check("sat cnt_cycle", cnt_cycle, 25);
      check("sat small cnt_cycle", s_cnt_cycle, 15);
      tick();

      for (int k = 0; k < 3000; k++) begin
         drive(($urandom_range(99) == 0),
               ($urandom_range(99) < 60),
               ($urandom_range(99) < 30),
               ($urandom_range(99) < 50),
               ($urandom_range(99) < 15),
               ($urandom_range(99) < 15));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
